// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM states and flag indices for alu_seq (ALU_DIV_EN adds the DIV state)
package alu_pkg;
    localparam logic [3:0] ALU_OP_ADD  = 4'h0;
    localparam logic [3:0] ALU_OP_SUB  = 4'h1;
    localparam logic [3:0] ALU_OP_MUL  = 4'h2;
    localparam logic [3:0] ALU_OP_SHL  = 4'h3;
    localparam logic [3:0] ALU_OP_SHR  = 4'h4;
    localparam logic [3:0] ALU_OP_INCA = 4'h5;
    localparam logic [3:0] ALU_OP_INCB = 4'h6;
    localparam logic [3:0] ALU_OP_DECA = 4'h7;
    localparam logic [3:0] ALU_OP_DECB = 4'h8;
    localparam logic [3:0] ALU_OP_EQ   = 4'h9;
    localparam logic [3:0] ALU_OP_GT   = 4'hA;
    localparam logic [3:0] ALU_OP_LT   = 4'hB;
    localparam logic [3:0] ALU_OP_DIV  = 4'hC;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

`ifdef ALU_DIV_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} alu_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_MUL} alu_state_e;
`endif
endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: shared shift-add multiply / restoring divide iteration datapath (divide only with ALU_DIV_EN)
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
`ifdef ALU_DIV_EN
    input  logic             div_i,
    output logic             b_zero_o,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] nxt_hi_o,
    output logic [WIDTH-1:0] nxt_lo_o,
    output logic             last_o
);
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   sum;
`ifdef ALU_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
`endif

    assign last_o = cnt_q == CNT_W'(1);
`ifdef ALU_DIV_EN
    assign b_zero_o = b_q == '0;
`endif

    // One iteration: hi/lo hold {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
`ifdef ALU_DIV_EN
        shifted  = {hi_q, lo_q[WIDTH-1]};
        ge       = shifted >= {1'b0, b_q};
        diff     = shifted[WIDTH-1:0] - b_q;
        nxt_hi_o = div_q ? (ge ? diff : shifted[WIDTH-1:0]) : sum[WIDTH:1];
        nxt_lo_o = div_q ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
`else
        nxt_hi_o = sum[WIDTH:1];
        nxt_lo_o = {sum[0], lo_q[WIDTH-1:1]};
`endif
    end

    // Load operands on start, then iterate until the counter drains
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
`ifdef ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (start_i) begin
            hi_q  <= '0;
            lo_q  <= a_i;
            b_q   <= b_i;
            cnt_q <= CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
            div_q <= div_i;
`endif
        end else if (cnt_q != '0) begin
            hi_q  <= nxt_hi_o;
            lo_q  <= nxt_lo_o;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-generic ALU with iterative multiply and Z/C/N/V flags (ALU_DIV_EN adds divide on opcode C)
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    input  logic [3:0]       ALU_Op_Code,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_RESULT,
    output logic [WIDTH-1:0] OUT_RESULT_HI,
    output logic [3:0]       OUT_FLAGS,
    output logic             OUT_VALID
);
    alu_state_e       state_q;
    logic [WIDTH-1:0] res_q, res_hi_q, res_d, x, y, nxt_hi, nxt_lo;
    logic [3:0]       flags_q, flags_d;
    logic             valid_q, is_sub, is_arith, ovf, carry, last, start;
    logic [WIDTH:0]   arith;
`ifdef ALU_DIV_EN
    logic             b_zero;
`endif

    assign IN_READY      = state_q == ST_IDLE;
    assign OUT_RESULT    = res_q;
    assign OUT_RESULT_HI = res_hi_q;
    assign OUT_FLAGS     = flags_q;
    assign OUT_VALID     = valid_q;
`ifdef ALU_DIV_EN
    assign start = IN_VALID && IN_READY && (ALU_Op_Code == ALU_OP_MUL || ALU_Op_Code == ALU_OP_DIV);
`else
    assign start = IN_VALID && IN_READY && ALU_Op_Code == ALU_OP_MUL;
`endif

    alu_iter_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .start_i  (start),
`ifdef ALU_DIV_EN
        .div_i    (ALU_Op_Code == ALU_OP_DIV),
        .b_zero_o (b_zero),
`endif
        .a_i      (IN_A),
        .b_i      (IN_B),
        .nxt_hi_o (nxt_hi),
        .nxt_lo_o (nxt_lo),
        .last_o   (last)
    );

    // Single-cycle result and flags; inc/dec reuse the add/sub path with a constant 1
    always_comb begin
        x        = (ALU_Op_Code == ALU_OP_INCB || ALU_Op_Code == ALU_OP_DECB) ? IN_B : IN_A;
        y        = (ALU_Op_Code == ALU_OP_ADD || ALU_Op_Code == ALU_OP_SUB) ? IN_B : WIDTH'(1);
        is_sub   = ALU_Op_Code inside {ALU_OP_SUB, ALU_OP_DECA, ALU_OP_DECB};
        is_arith = is_sub || ALU_Op_Code inside {ALU_OP_ADD, ALU_OP_INCA, ALU_OP_INCB};
        arith    = is_sub ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
        ovf      = (is_sub ? x[WIDTH-1] != y[WIDTH-1] : x[WIDTH-1] == y[WIDTH-1]) && arith[WIDTH-1] != x[WIDTH-1];
        res_d    = is_arith                  ? arith[WIDTH-1:0] :
                   ALU_Op_Code == ALU_OP_SHL ? {IN_A[WIDTH-2:0], 1'b0} :
                   ALU_Op_Code == ALU_OP_SHR ? {1'b0, IN_A[WIDTH-1:1]} :
                   ALU_Op_Code == ALU_OP_EQ  ? WIDTH'(IN_A == IN_B) :
                   ALU_Op_Code == ALU_OP_GT  ? WIDTH'(IN_A > IN_B) :
                   ALU_Op_Code == ALU_OP_LT  ? WIDTH'(IN_A < IN_B) : IN_A;
        carry    = is_arith                  ? arith[WIDTH] :
                   ALU_Op_Code == ALU_OP_SHL ? IN_A[WIDTH-1] :
                   ALU_Op_Code == ALU_OP_SHR ? IN_A[0] : 1'b0;
        flags_d  = '0;
        flags_d[FLAG_V] = is_arith && ovf;
        flags_d[FLAG_N] = res_d[WIDTH-1];
        flags_d[FLAG_C] = carry;
        flags_d[FLAG_Z] = res_d == '0;
    end

    // Control FSM with registered results; multi-cycle ops complete when the iterator reports its last step
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            res_q    <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (IN_VALID) begin
                    if (ALU_Op_Code == ALU_OP_MUL) state_q <= ST_MUL;
`ifdef ALU_DIV_EN
                    else if (ALU_Op_Code == ALU_OP_DIV) state_q <= ST_DIV;
`endif
                    else begin
                        res_q    <= res_d;
                        res_hi_q <= '0;
                        flags_q  <= flags_d;
                        valid_q  <= 1'b1;
                    end
                end
                ST_MUL: if (last) begin
                    res_q    <= nxt_lo;
                    res_hi_q <= nxt_hi;
                    flags_q  <= {1'b0, nxt_lo[WIDTH-1], nxt_hi != '0, nxt_lo == '0 && nxt_hi == '0};
                    valid_q  <= 1'b1;
                    state_q  <= ST_IDLE;
                end
`ifdef ALU_DIV_EN
                ST_DIV: if (last) begin
                    res_q    <= nxt_lo;
                    res_hi_q <= nxt_hi;
                    flags_q  <= {b_zero, nxt_lo[WIDTH-1], 1'b0, nxt_lo == '0};
                    valid_q  <= 1'b1;
                    state_q  <= ST_IDLE;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (divide vectors when ALU_DIV_EN is defined)
module tb_alu_seq;
    import alu_pkg::*;
    localparam int W = 8;

    logic         CLK = 1'b0, RESET = 1'b1, IN_VALID = 1'b0;
    logic [W-1:0] IN_A = '0, IN_B = '0;
    logic [3:0]   op = '0;
    logic         IN_READY, OUT_VALID;
    logic [W-1:0] OUT_RESULT, OUT_RESULT_HI;
    logic [3:0]   OUT_FLAGS;
    int           tests = 0, fails = 0;

    alu_seq #(.WIDTH(W)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IN_A          (IN_A),
        .IN_B          (IN_B),
        .ALU_Op_Code   (op),
        .IN_VALID      (IN_VALID),
        .IN_READY      (IN_READY),
        .OUT_RESULT    (OUT_RESULT),
        .OUT_RESULT_HI (OUT_RESULT_HI),
        .OUT_FLAGS     (OUT_FLAGS),
        .OUT_VALID     (OUT_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        op = o; IN_A = a; IN_B = b; IN_VALID = 1'b1;
    endtask

    task automatic single(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        drive(o, a, b);
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] r, input logic [W-1:0] hi, input logic [3:0] f);
        check({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
        check({tag, "_res"}, 32'(OUT_RESULT), 32'(r));
        check({tag, "_hi"}, 32'(OUT_RESULT_HI), 32'(hi));
        check({tag, "_flags"}, 32'(OUT_FLAGS), 32'(f));
    endtask

    // Issue a multi-cycle op, pulse IN_VALID while busy, return edges to completion and ready-low samples
    task automatic multi(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int edges, output int low);
        drive(o, a, b);
        @(negedge CLK);
        IN_VALID = 1'b0;
        low = int'(!IN_READY);
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            edges++;
            if (OUT_VALID) break;
            if (!IN_READY) low++;
            op = ALU_OP_ADD; IN_A = 8'd1; IN_B = 8'd1; IN_VALID = edges[0];
        end
        IN_VALID = 1'b0;
    endtask

    initial begin
        int edges, low, pulses;
        repeat (2) @(negedge CLK);
        check("rst_valid", 32'(OUT_VALID), 32'd0);
        check("rst_res", 32'(OUT_RESULT), 32'd0);
        check("rst_hi", 32'(OUT_RESULT_HI), 32'd0);
        check("rst_flags", 32'(OUT_FLAGS), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_ready", 32'(IN_READY), 32'd1);

        single(ALU_OP_ADD, 8'd200, 8'd100);  check_out("add", 8'd44, 8'd0, 4'b0010);
        single(ALU_OP_ADD, 8'd0, 8'd0);      check_out("add_zero", 8'd0, 8'd0, 4'b0001);
        single(ALU_OP_SUB, 8'h80, 8'h01);    check_out("sub_ovf", 8'h7F, 8'd0, 4'b1000);
        single(ALU_OP_SUB, 8'h00, 8'h01);    check_out("sub_wrap", 8'hFF, 8'd0, 4'b0110);
        single(ALU_OP_DECA, 8'h00, 8'h33);   check_out("deca", 8'hFF, 8'd0, 4'b0110);
        single(ALU_OP_DECB, 8'h33, 8'h10);   check_out("decb", 8'h0F, 8'd0, 4'b0000);
        single(ALU_OP_INCA, 8'h7F, 8'h00);   check_out("inca", 8'h80, 8'd0, 4'b1100);
        single(ALU_OP_INCB, 8'h12, 8'hFF);   check_out("incb", 8'h00, 8'd0, 4'b0011);
        single(ALU_OP_SHL, 8'h81, 8'h00);    check_out("shl", 8'h02, 8'd0, 4'b0010);
        single(ALU_OP_SHR, 8'h81, 8'h00);    check_out("shr", 8'h40, 8'd0, 4'b0010);
        single(ALU_OP_GT, 8'd9, 8'd3);       check_out("gt", 8'd1, 8'd0, 4'b0000);
        single(ALU_OP_LT, 8'd3, 8'd9);       check_out("lt", 8'd1, 8'd0, 4'b0000);
        single(4'hF, 8'h55, 8'h11);          check_out("pass", 8'h55, 8'd0, 4'b0000);

        drive(ALU_OP_EQ, 8'd5, 8'd5);
        @(negedge CLK);
        check("b2b_ready", 32'(IN_READY), 32'd1);
        check_out("b2b_eq", 8'd1, 8'd0, 4'b0000);
        op = ALU_OP_GT; IN_A = 8'd3; IN_B = 8'd9;
        @(negedge CLK);
        IN_VALID = 1'b0;
        check_out("b2b_gt", 8'd0, 8'd0, 4'b0001);
        @(negedge CLK);
        check("idle_valid", 32'(OUT_VALID), 32'd0);
        check("idle_hold", 32'(OUT_RESULT), 32'd0);

        multi(ALU_OP_MUL, 8'd255, 8'd255, edges, low);
        check("mul_lat", 32'(edges), 32'd8);
        check("mul_ready_low", 32'(low), 32'd8);
        check_out("mul_ff", 8'h01, 8'hFE, 4'b0010);
        check("mul_ready_back", 32'(IN_READY), 32'd1);
        @(negedge CLK);
        check("mul_pulse_once", 32'(OUT_VALID), 32'd0);
        check("mul_hold", 32'(OUT_RESULT_HI), 32'hFE);

        multi(ALU_OP_MUL, 8'd13, 8'd11, edges, low);
        check("mul2_lat", 32'(edges), 32'd8);
        check_out("mul2", 8'h8F, 8'h00, 4'b0100);
        multi(ALU_OP_MUL, 8'd0, 8'd200, edges, low);
        check_out("mul_zero", 8'h00, 8'h00, 4'b0001);

`ifdef ALU_DIV_EN
        multi(ALU_OP_DIV, 8'd200, 8'd7, edges, low);
        check("div_lat", 32'(edges), 32'd8);
        check_out("div", 8'd28, 8'd4, 4'b0000);
        multi(ALU_OP_DIV, 8'd9, 8'd0, edges, low);
        check_out("div_zero", 8'hFF, 8'd9, 4'b1100);
`else
        single(ALU_OP_DIV, 8'h3C, 8'h05);    check_out("opc_pass", 8'h3C, 8'd0, 4'b0000);
`endif

        single(ALU_OP_ADD, 8'd1, 8'd2);      check_out("pre_rst", 8'd3, 8'd0, 4'b0000);
        drive(ALU_OP_MUL, 8'd15, 8'd17);
        @(negedge CLK);
        IN_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        op = ALU_OP_ADD; IN_A = 8'd5; IN_B = 8'd5; IN_VALID = 1'b1;
        @(negedge CLK);
        check("abort_valid", 32'(OUT_VALID), 32'd0);
        check("abort_res", 32'(OUT_RESULT), 32'd0);
        check("abort_hi", 32'(OUT_RESULT_HI), 32'd0);
        check("abort_flags", 32'(OUT_FLAGS), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("abort_ready", 32'(IN_READY), 32'd1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (OUT_VALID) pulses++;
            @(negedge CLK);
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
        check("abort_res_after", 32'(OUT_RESULT), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
